// File: rtl/gpr_seq_pkg.sv
// gpr_seq_pkg: shared constants and types for the GPR transfer sequencer.
//   OPW              - width of the operation-class field
//   NREG             - number of general-purpose registers (R0..R15)
//   OP_ALU3..OP_MOVE - operation class codes
//   state_t          - sequencer state encoding
package gpr_seq_pkg;

  localparam int OPW  = 2;
  localparam int NREG = 16;

  localparam logic [OPW-1:0] OP_ALU3 = 2'd0;  // ra <- rb op rc
  localparam logic [OPW-1:0] OP_ALUI = 2'd1;  // ra <- rb op C
  localparam logic [OPW-1:0] OP_ADDR = 2'd2;  // ra <- (rb | 0 if R0) + C
  localparam logic [OPW-1:0] OP_MOVE = 2'd3;  // ra <- rb

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TY   = 3'd1,
    ST_TZ   = 3'd2,
    ST_TW   = 3'd3,
    ST_TMV  = 3'd4
  } state_t;

endpackage

// File: rtl/gpr_seq_if.sv
// gpr_seq_if: request and control-strobe bundle between decode, sequencer
// and register bank.
//   start/op/ra/rb/rc/hold - request and stall, driven by the master
//   GRin/GRout             - one-hot register write / bus-drive enables
//   BAout                  - base-address read (R0 reads as zero)
//   Yin/Zin/Zout/Cout      - Y load, Z load, Z to bus, immediate to bus
//   busy/done              - sequencer status
interface gpr_seq_if import gpr_seq_pkg::*; ();

  logic            start;
  logic [OPW-1:0]  op;
  logic [3:0]      ra;
  logic [3:0]      rb;
  logic [3:0]      rc;
  logic            hold;
  logic [NREG-1:0] GRin;
  logic [NREG-1:0] GRout;
  logic            BAout;
  logic            Yin;
  logic            Zin;
  logic            Zout;
  logic            Cout;
  logic            busy;
  logic            done;

  modport master (
    output start, op, ra, rb, rc, hold,
    input  GRin, GRout, BAout, Yin, Zin, Zout, Cout, busy, done
  );

  modport slave (
    input  start, op, ra, rb, rc, hold,
    output GRin, GRout, BAout, Yin, Zin, Zout, Cout, busy, done
  );

endinterface

// File: rtl/gpr_seq_dec4to16.sv
// dec4to16: 4-to-16 one-hot decoder with enable.
//   addr   - register number
//   en     - when 0 the output is all zeros
//   onehot - bit addr set when enabled
module dec4to16 (
  input  logic [3:0]  addr,
  input  logic        en,
  output logic [15:0] onehot
);

  // one-hot decode of the register number
  always_comb begin
    onehot = 16'h0000;
    if (en) begin
      onehot = 16'h0001 << addr;
    end else begin
      onehot = 16'h0000;
    end
  end

endmodule

// File: rtl/gpr_seq.sv
// gpr_seq: steps one decoded register operation through its bus cycles.
//   clk     - rising-edge clock
//   clear_n - asynchronous active-low reset
//   bus     - request inputs and register/strobe outputs (gpr_seq_if.slave)
// Outputs are Moore-decoded from the state and the fields latched when the
// request was accepted; hold blanks every strobe while freezing the state.
module gpr_seq import gpr_seq_pkg::*; (
  input  logic      clk,
  input  logic      clear_n,
  gpr_seq_if.slave  bus
);

  state_t         state;
  state_t         next_state;
  logic [OPW-1:0] op_l;
  logic [3:0]     ra_l;
  logic [3:0]     rb_l;
  logic [3:0]     rc_l;

  logic           stall;
  logic           gin_en;
  logic [3:0]     gin_sel;
  logic           gout_en;
  logic [3:0]     gout_sel;
  logic [15:0]    gin_vec;
  logic [15:0]    gout_vec;

  // hold only matters once an operation is in flight
  assign stall = bus.hold && (state != ST_IDLE);

  // state register
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // request fields are captured only on an accepted start
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      op_l <= 2'd0;
      ra_l <= 4'd0;
      rb_l <= 4'd0;
      rc_l <= 4'd0;
    end else if ((state == ST_IDLE) && bus.start) begin
      op_l <= bus.op;
      ra_l <= bus.ra;
      rb_l <= bus.rb;
      rc_l <= bus.rc;
    end
  end

  // next-state logic
  always_comb begin
    next_state = state;
    if (stall) begin
      next_state = state;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            next_state = (bus.op == OP_MOVE) ? ST_TMV : ST_TY;
          end else begin
            next_state = ST_IDLE;
          end
        end
        ST_TY:   next_state = ST_TZ;
        ST_TZ:   next_state = ST_TW;
        ST_TW:   next_state = ST_IDLE;
        ST_TMV:  next_state = ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // output decode from state and latched fields
  always_comb begin
    gin_en    = 1'b0;
    gin_sel   = 4'd0;
    gout_en   = 1'b0;
    gout_sel  = 4'd0;
    bus.BAout = 1'b0;
    bus.Yin   = 1'b0;
    bus.Zin   = 1'b0;
    bus.Zout  = 1'b0;
    bus.Cout  = 1'b0;
    bus.done  = 1'b0;
    if (stall) begin
      // everything stays blanked while held
      gin_en  = 1'b0;
      gout_en = 1'b0;
    end else begin
      case (state)
        ST_TY: begin
          gout_en   = 1'b1;
          gout_sel  = rb_l;
          bus.Yin   = 1'b1;
          bus.BAout = (op_l == OP_ADDR);
        end
        ST_TZ: begin
          bus.Zin = 1'b1;
          if (op_l == OP_ALU3) begin
            gout_en  = 1'b1;
            gout_sel = rc_l;
          end else begin
            bus.Cout = 1'b1;
          end
        end
        ST_TW: begin
          bus.Zout = 1'b1;
          gin_en   = 1'b1;
          gin_sel  = ra_l;
          bus.done = 1'b1;
        end
        ST_TMV: begin
          gout_en  = 1'b1;
          gout_sel = rb_l;
          gin_en   = 1'b1;
          gin_sel  = ra_l;
          bus.done = 1'b1;
        end
        default: begin
          gin_en  = 1'b0;
          gout_en = 1'b0;
        end
      endcase
    end
  end

  dec4to16 u_dec_in (
    .addr   (gin_sel),
    .en     (gin_en),
    .onehot (gin_vec)
  );

  dec4to16 u_dec_out (
    .addr   (gout_sel),
    .en     (gout_en),
    .onehot (gout_vec)
  );

  assign bus.GRin  = gin_vec;
  assign bus.GRout = gout_vec;
  assign bus.busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_gpr_seq.sv
// tb_gpr_seq: directed scoreboard bench for gpr_seq. Stimulus pushes the
// expected per-cycle output vector of every busy cycle; a monitor pops and
// compares on each falling edge while busy, and checks all-zero outputs
// while idle.
module tb_gpr_seq;
  import gpr_seq_pkg::*;

  typedef struct packed {
    logic [15:0] gin;
    logic [15:0] gout;
    logic        ba;
    logic        yin;
    logic        zin;
    logic        zout;
    logic        cout;
    logic        done;
  } exp_t;

  logic clk;
  logic clear_n;
  int   checks;
  int   errors;
  exp_t expq[$];

  gpr_seq_if bus ();

  gpr_seq dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t actual_vec();
    exp_t v;
    v = {bus.GRin, bus.GRout, bus.BAout, bus.Yin, bus.Zin, bus.Zout, bus.Cout, bus.done};
    return v;
  endfunction

  task automatic push(input logic [15:0] gin, input logic [15:0] gout, input logic ba,
                      input logic yin, input logic zin, input logic zout,
                      input logic cout, input logic dn);
    exp_t e;
    e = {gin, gout, ba, yin, zin, zout, cout, dn};
    expq.push_back(e);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (clear_n) begin
      if (bus.busy) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL busy_unexpected actual=%h required=no busy cycle", actual_vec());
        end else begin
          exp_t e;
          e = expq.pop_front();
          if (actual_vec() !== e) begin
            errors++;
            $display("FAIL busy_cycle actual=%h required=%h", actual_vec(), e);
          end
        end
      end else begin
        checks++;
        if (actual_vec() !== '0) begin
          errors++;
          $display("FAIL idle_outputs actual=%h required=0", actual_vec());
        end
      end
    end
  end

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // issue one operation; inputs are scrambled after acceptance so only latched fields matter
  task automatic run_op(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input int hold_tz, input bit noise,
                        input bit hold_idle);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = o; bus.ra = a; bus.rb = b; bus.rc = c;
    bus.hold = hold_idle;
    @(posedge clk); #1;
    bus.hold = 1'b0;
    bus.start = noise;
    bus.op = ~o; bus.ra = ~a; bus.rb = ~b; bus.rc = ~c;
    check_eq("busy_after_start", {63'd0, bus.busy}, 64'd1);
    if (o != OP_MOVE) begin
      @(posedge clk); #1;
      if (hold_tz > 0) begin
        bus.hold = 1'b1;
        repeat (hold_tz) begin
          @(posedge clk); #1;
        end
        bus.hold = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    check_eq("busy_after_done", {63'd0, bus.busy}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'd0; bus.ra = 4'd0; bus.rb = 4'd0; bus.rc = 4'd0;
    bus.hold = 1'b0;
    #2;
    check_eq("reset_outputs", {31'd0, actual_vec()}, 64'd0);
    check_eq("reset_busy", {63'd0, bus.busy}, 64'd0);
    #10;
    clear_n = 1'b1;

    // ALU3 ra=3 rb=5 rc=7
    push(16'h0000, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(16'h0000, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(16'h0008, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op(OP_ALU3, 4'd3, 4'd5, 4'd7, 0, 1'b0, 1'b0);

    // ADDR ra=2 rb=0
    push(16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    push(16'h0004, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op(OP_ADDR, 4'd2, 4'd0, 4'd9, 0, 1'b0, 1'b0);

    // MOVE ra=15 rb=1
    push(16'h8000, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(OP_MOVE, 4'd15, 4'd1, 4'd0, 0, 1'b0, 1'b0);

    // ALUI ra=4 rb=6 with two hold cycles in TZ
    push(16'h0000, 16'h0040, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    push(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op(OP_ALUI, 4'd4, 4'd6, 4'd2, 2, 1'b0, 1'b0);

    // ALU3 ra=0 rb=12 rc=15, start while busy, hold during the accepting IDLE cycle
    push(16'h0000, 16'h1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op(OP_ALU3, 4'd0, 4'd12, 4'd15, 0, 1'b1, 1'b1);

    // ADDR with nonzero base ra=7 rb=3
    push(16'h0000, 16'h0008, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    push(16'h0080, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op(OP_ADDR, 4'd7, 4'd3, 4'd1, 0, 1'b0, 1'b0);

    // MOVE ra=rb=9
    push(16'h0200, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(OP_MOVE, 4'd9, 4'd9, 4'd0, 0, 1'b0, 1'b0);

    // asynchronous reset during TZ of an ALUI
    push(16'h0000, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OP_ALUI; bus.ra = 4'd5; bus.rb = 4'd1; bus.rc = 4'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check_eq("tz_before_reset", {31'd0, actual_vec()}, 64'h0000_0000_0000_000A);
    #1 clear_n = 1'b0;
    #1;
    check_eq("async_reset_outputs", {31'd0, actual_vec()}, 64'd0);
    check_eq("async_reset_busy", {63'd0, bus.busy}, 64'd0);
    #3 clear_n = 1'b1;

    // recovery after reset: ALUI ra=1 rb=14
    push(16'h0000, 16'h4000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    push(16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op(OP_ALUI, 4'd1, 4'd14, 4'd3, 0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_eq("scoreboard_empty", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gpr_seq.md
# gpr_seq

Register-transfer sequencer for the R0–R15 general-purpose register bank in the Mini SRC datapath. It accepts one decoded register operation at a time, with an opcode class and the ra/rb/rc fields. It then steps through the bus cycles for that operation and drives the one-hot `GRin`/`GRout` vectors, `BAout`, and the Y/Z/C-immediate bus strobes. It sits between instruction decode and the register bank, replacing hand-driven control signals in the testbenches and the later control unit.

## Interface
- `OPW`, 2: width of the operation-class field.
- `clk` input 1: system clock, rising-edge.
- `clear_n` input 1: asynchronous active-low reset.
- `start` input 1: request; sampled only in IDLE.
- `op` input `OPW`: operation class. ALU3 = 0 (ra ← rb op rc), ALUI = 1 (ra ← rb op C), ADDR = 2 (ra ← (rb, or 0 if rb=R0) + C), MOVE = 3 (ra ← rb).
- `ra`, `rb`, `rc` input 4 each: register numbers.
- `hold` input 1: stall request, e.g. a memory wait.
- `GRin` output 16: one-hot register write-enable vector.
- `GRout` output 16: one-hot register read (bus drive) vector.
- `BAout` output 1: base-address read; R0 reads as zero.
- `Yin`, `Zin`, `Zout`, `Cout` output 1 each: Y load, Z load, Z drives bus, immediate drives bus.
- `busy` output 1: not IDLE.
- `done` output 1: one-cycle pulse during the write-back cycle.

## Operation
- States: IDLE, TY, TZ, TW, TMV. The encoding is a package enum.
- IDLE with `start`=1 at a rising edge:
  - latch `op`, `ra`, `rb`, `rc`;
  - next state is TMV if op=MOVE, otherwise TY.
- IDLE with `start`=0: stay in IDLE.
- `start` outside IDLE is ignored; no queueing.
- TY: `GRout[rb]`=1 and `Yin`=1. `BAout`=1 only when op=ADDR. Next state TZ.
- TZ: `Zin`=1. If op=ALU3, `GRout[rc]`=1; else `Cout`=1. Next state TW.
- TW: `Zout`=1, `GRin[ra]`=1, `done`=1. Next state IDLE.
- TMV: `GRout[rb]`=1, `GRin[ra]`=1, `done`=1. Next state IDLE.
- All outputs are Moore-decoded from the state and the latched fields, never from the live `ra`/`rb`/`rc`/`op` inputs.
- `hold`=1 in any non-IDLE state:
  - the state is frozen;
  - every strobe, `GRin`, `GRout`, `BAout` and `done` is forced to 0;
  - `busy` stays 1.
- `hold` in IDLE has no effect, and `start` is still accepted.
- ra=rb in MOVE is legal; the register is rewritten with its own value.
- Writes to R0 are legal and drive `GRin[0]`.
- `GRin` and `GRout` each have at most one bit set in every cycle.

## Timing
- Reset (`clear_n`=0, asynchronous): state is IDLE, latched fields are 0, and every output is 0. Reset takes effect immediately, including mid-operation.
- After `clear_n` rises, the first accepted `start` is at the next rising edge.
- Latency from the `start` edge to the `done` cycle:
  - ALU3/ALUI/ADDR: 3 cycles (TY, TZ, TW);
  - MOVE: 1 cycle.
  - Each `hold` cycle adds 1.
- `busy` is high from the cycle after an accepted `start` through the `done` cycle inclusive.
- Back-to-back throughput: the next `start` is accepted on the edge that leaves TW/TMV only if it is sampled in IDLE, so there is at least one IDLE cycle between operations.

## Structure
- Package `gpr_seq_pkg` holds:
  - the `op` class localparams (ALU3, ALUI, ADDR, MOVE);
  - the state enum;
  - the register-count constant of 16.
- Sub-module `dec4to16`: 4-bit address plus enable in, 16-bit one-hot out. It is instantiated twice, once for the `GRin` path and once for the `GRout` path.
- Target size is about 150–250 lines including the decoder.

## Test plan
- Reset, then op=ALU3, ra=3, rb=5, rc=7, `start` → three cycles later:
  - TY: `GRout`=0x0020, `Yin`=1;
  - TZ: `GRout`=0x0080, `Zin`=1;
  - TW: `GRin`=0x0008, `Zout`=1, `done`=1;
  - then IDLE with `busy`=0.
- op=ADDR, ra=2, rb=0 → TY: `GRout`=0x0001, `BAout`=1, `Yin`=1; TZ: `Cout`=1, `GRout`=0; TW: `GRin`=0x0004.
- op=MOVE, ra=15, rb=1 → a single cycle with `GRout`=0x0002, `GRin`=0x8000, `done`=1.
- ALUI with `hold`=1 for 2 cycles in TZ → outputs are 0 while held, the state resumes in TZ, and `done` arrives 2 cycles late.
- `clear_n` pulsed low during TZ → all outputs are 0 asynchronously and the state is IDLE. A `start` asserted while `busy`=1 is ignored, and the latched fields are unchanged.
